// File: rtl/gshare_pkg.sv
// Shared definitions for the branch direction predictors.
package gshare_pkg;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Saturating up/down counter step. The counter travels in a 32-bit container;
  // the caller truncates the result back to its own width.
  function automatic logic [31:0] sat_update(input logic [31:0] ctr,
                                             input logic        taken,
                                             input int unsigned width);
    logic [31:0] ctr_max;
    ctr_max = ~(32'hFFFF_FFFF << width);
    if (taken) begin
      sat_update = (ctr >= ctr_max) ? ctr_max : ctr + 32'd1;
    end else begin
      sat_update = (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    end
  endfunction

endpackage

// File: rtl/gshare_branch_history_reg.sv
// Global branch history shift register; newest outcome enters at bit 0.
module branch_history_reg #(
  parameter int HIST_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic                 shift_in,
  output logic [HIST_BITS-1:0] history
);

  generate
    if (HIST_BITS == 1) begin : g_single
      // Single-bit history simply records the latest outcome.
      always_ff @(posedge clk) begin
        if (reset)         history <= '0;
        else if (shift_en) history <= shift_in;
      end
    end else begin : g_multi
      // Shift left, dropping the oldest outcome.
      always_ff @(posedge clk) begin
        if (reset)         history <= '0;
        else if (shift_en) history <= {history[HIST_BITS-2:0], shift_in};
      end
    end
  endgenerate

endmodule

// File: rtl/gshare_predictor.sv
// Bimodal / gshare branch direction predictor with a registered prediction
// and non-speculative history update at resolution.
module gshare_predictor
  import gshare_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 4,
  parameter int MODE       = 1,
  parameter int INIT       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  request,
  input  logic [INDEX_BITS-1:0] req_pc,
  output logic                  prediction,
  output logic                  pred_valid,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  result,
  input  logic [INDEX_BITS-1:0] res_index,
  input  logic                  taken
);

  localparam int ENTRIES = 2 ** INDEX_BITS;

  logic [CTR_BITS-1:0]   ctr_table [ENTRIES];
  logic [HIST_BITS-1:0]  ghr;
  logic [INDEX_BITS-1:0] idx;
  logic [31:0]           ctr_upd;
  logic [CTR_BITS-1:0]   ctr_next;

  branch_history_reg #(.HIST_BITS(HIST_BITS)) u_ghr (
    .clk      (clk),
    .reset    (reset),
    .shift_en (result),
    .shift_in (taken),
    .history  (ghr)
  );

  // Index hash on the pre-update history; bimodal ignores the GHR.
  always_comb begin
    idx = req_pc;
    if (MODE == MODE_GSHARE) idx = req_pc ^ INDEX_BITS'(ghr);
  end

  // Next value for the entry being trained.
  always_comb begin
    ctr_upd  = sat_update(32'(ctr_table[res_index]), taken, CTR_BITS);
    ctr_next = ctr_upd[CTR_BITS-1:0];
  end

  // Counter table; nonblocking write keeps a same-edge read on the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= CTR_BITS'(INIT);
    end else if (result) begin
      ctr_table[res_index] <= ctr_next;
    end
  end

  // Registered prediction; index and direction hold between requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      prediction <= 1'b0;
      pred_valid <= 1'b0;
      pred_index <= '0;
    end else if (request) begin
      prediction <= ctr_table[idx][CTR_BITS-1];
      pred_index <= idx;
      pred_valid <= 1'b1;
    end else begin
      pred_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench: gshare, bimodal and 3-bit-counter instances share stimulus;
// every test begins with a reset so instances do not disturb each other.
module tb_gshare_predictor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       request = 1'b0;
  logic [3:0] req_pc = '0;
  logic       result = 1'b0;
  logic [3:0] res_index = '0;
  logic       taken = 1'b0;

  logic       g_pred, g_valid;
  logic [3:0] g_index;
  logic       b_pred, b_valid;
  logic [3:0] b_index;
  logic       c_pred, c_valid;
  logic [3:0] c_index;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  gshare_predictor #(.INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(4), .MODE(1), .INIT(1)) dut_g (
    .clk(clk), .reset(reset), .request(request), .req_pc(req_pc),
    .prediction(g_pred), .pred_valid(g_valid), .pred_index(g_index),
    .result(result), .res_index(res_index), .taken(taken));

  gshare_predictor #(.INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(4), .MODE(0), .INIT(1)) dut_b (
    .clk(clk), .reset(reset), .request(request), .req_pc(req_pc),
    .prediction(b_pred), .pred_valid(b_valid), .pred_index(b_index),
    .result(result), .res_index(res_index), .taken(taken));

  gshare_predictor #(.INDEX_BITS(4), .CTR_BITS(3), .HIST_BITS(4), .MODE(0), .INIT(3)) dut_c (
    .clk(clk), .reset(reset), .request(request), .req_pc(req_pc),
    .prediction(c_pred), .pred_valid(c_valid), .pred_index(c_index),
    .result(result), .res_index(res_index), .taken(taken));

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; request = 1'b0; result = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic train(input logic [3:0] i, input logic t);
    request = 1'b0; result = 1'b1; res_index = i; taken = t;
    tick();
    result = 1'b0;
  endtask

  task automatic req(input logic [3:0] pc);
    result = 1'b0; request = 1'b1; req_pc = pc;
    tick();
    request = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; request = 1'b1; req_pc = 4'd9; result = 1'b1; res_index = 4'd9; taken = 1'b1;
    tick();
    reset = 1'b0; request = 1'b0; result = 1'b0;
    total++; if (g_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", g_valid); else passed++;
    total++; if (g_index !== 4'd0) $display("FAIL reset_index got %0d exp 0", g_index); else passed++;
    total++; if (g_pred !== 1'b0) $display("FAIL reset_pred got %0b exp 0", g_pred); else passed++;
    req(4'd3);
    total++; if (g_valid !== 1'b1) $display("FAIL first_valid got %0b exp 1", g_valid); else passed++;
    total++; if (g_index !== 4'd3) $display("FAIL first_index got %0d exp 3", g_index); else passed++;
    total++; if (g_pred !== 1'b0) $display("FAIL first_pred got %0b exp 0", g_pred); else passed++;
    tick();
    total++; if (g_valid !== 1'b0) $display("FAIL idle_valid got %0b exp 0", g_valid); else passed++;
    total++; if (g_index !== 4'd3) $display("FAIL idle_index_hold got %0d exp 3", g_index); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    train(4'd5, 1'b1);
    req(4'd5);
    total++; if (b_pred !== 1'b1) $display("FAIL sat_ctr2 got %0b exp 1", b_pred); else passed++;
    total++; if (b_index !== 4'd5) $display("FAIL sat_index got %0d exp 5", b_index); else passed++;
    for (int k = 0; k < 3; k++) train(4'd5, 1'b1);
    train(4'd5, 1'b0);
    req(4'd5);
    total++; if (b_pred !== 1'b1) $display("FAIL sat_top_then_dec got %0b exp 1", b_pred); else passed++;
    train(4'd5, 1'b0);
    train(4'd5, 1'b0);
    req(4'd5);
    total++; if (b_pred !== 1'b0) $display("FAIL sat_ctr0 got %0b exp 0", b_pred); else passed++;
    train(4'd5, 1'b0);
    req(4'd5);
    total++; if (b_pred !== 1'b0) $display("FAIL sat_floor got %0b exp 0", b_pred); else passed++;
    // From a floor of 0, two taken reach 2; a wrapped floor would not.
    train(4'd5, 1'b1);
    req(4'd5);
    total++; if (b_pred !== 1'b0) $display("FAIL sat_floor_up1 got %0b exp 0", b_pred); else passed++;
    train(4'd5, 1'b1);
    req(4'd5);
    total++; if (b_pred !== 1'b1) $display("FAIL sat_floor_up2 got %0b exp 1", b_pred); else passed++;
  endtask

  task automatic test_history();
    do_reset();
    train(4'd12, 1'b1);
    train(4'd12, 1'b1);
    train(4'd12, 1'b0);
    train(4'd12, 1'b1);
    req(4'b0001);
    total++; if (g_index !== 4'b1100) $display("FAIL hist_index got %0d exp 12", g_index); else passed++;
    total++; if (g_pred !== 1'b1) $display("FAIL hist_pred got %0b exp 1", g_pred); else passed++;
    total++; if (b_index !== 4'b0001) $display("FAIL bimodal_index got %0d exp 1", b_index); else passed++;
    total++; if (b_pred !== 1'b0) $display("FAIL bimodal_pred got %0b exp 0", b_pred); else passed++;
  endtask

  task automatic test_collision();
    do_reset();
    request = 1'b1; req_pc = 4'd7; result = 1'b1; res_index = 4'd7; taken = 1'b1;
    tick();
    request = 1'b0; result = 1'b0;
    total++; if (b_pred !== 1'b0) $display("FAIL collide_old got %0b exp 0", b_pred); else passed++;
    total++; if (b_valid !== 1'b1) $display("FAIL collide_valid got %0b exp 1", b_valid); else passed++;
    req(4'd7);
    total++; if (b_pred !== 1'b1) $display("FAIL collide_new got %0b exp 1", b_pred); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    train(4'd6, 1'b1);
    request = 1'b1; req_pc = 4'd6;
    tick();
    total++; if (b_pred !== 1'b1 || b_index !== 4'd6) $display("FAIL b2b_first got pred=%0b idx=%0d exp pred=1 idx=6", b_pred, b_index); else passed++;
    req_pc = 4'd8;
    tick();
    request = 1'b0;
    total++; if (b_valid !== 1'b1) $display("FAIL b2b_valid got %0b exp 1", b_valid); else passed++;
    total++; if (b_pred !== 1'b0 || b_index !== 4'd8) $display("FAIL b2b_second got pred=%0b idx=%0d exp pred=0 idx=8", b_pred, b_index); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    train(4'd2, 1'b1);
    train(4'd2, 1'b1);
    req(4'd2);
    total++; if (b_pred !== 1'b1) $display("FAIL mid_pre_pred got %0b exp 1", b_pred); else passed++;
    reset = 1'b1; request = 1'b1; req_pc = 4'd2; result = 1'b1; res_index = 4'd2; taken = 1'b1;
    tick();
    reset = 1'b0; request = 1'b0; result = 1'b0;
    total++; if (b_valid !== 1'b0) $display("FAIL mid_valid got %0b exp 0", b_valid); else passed++;
    total++; if (b_pred !== 1'b0) $display("FAIL mid_pred got %0b exp 0", b_pred); else passed++;
    req(4'd2);
    total++; if (b_pred !== 1'b0) $display("FAIL mid_ctr_init got %0b exp 0", b_pred); else passed++;
    total++; if (g_index !== 4'd2) $display("FAIL mid_ghr_clear got %0d exp 2", g_index); else passed++;
  endtask

  task automatic test_ctr3();
    do_reset();
    req(4'd0);
    total++; if (c_pred !== 1'b0) $display("FAIL c3_init got %0b exp 0", c_pred); else passed++;
    train(4'd0, 1'b1);
    req(4'd0);
    total++; if (c_pred !== 1'b1) $display("FAIL c3_ctr4 got %0b exp 1", c_pred); else passed++;
    for (int k = 0; k < 10; k++) train(4'd0, 1'b1);
    for (int k = 0; k < 3; k++) train(4'd0, 1'b0);
    req(4'd0);
    total++; if (c_pred !== 1'b1) $display("FAIL c3_cap_dec got %0b exp 1", c_pred); else passed++;
    train(4'd0, 1'b0);
    req(4'd0);
    total++; if (c_pred !== 1'b0) $display("FAIL c3_ctr3 got %0b exp 0", c_pred); else passed++;
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_history();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_ctr3();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised branch direction predictor: a table of 2^INDEX_BITS saturating counters plus a global history register (GHR).
- Selectable bimodal (PC-indexed) or gshare (PC XOR GHR) indexing.
- The fetch stage issues a request and gets a registered prediction plus the table index used.
- The execute stage returns the resolved outcome with that index so the same entry is trained.

Parameters:
- INDEX_BITS, 4, log2 of table entries; also the PC bits used.
- CTR_BITS, 2, saturating counter width (>=1); prediction = counter MSB.
- HIST_BITS, 4, GHR length; must satisfy 1 <= HIST_BITS <= INDEX_BITS.
- MODE, 1, 0 = bimodal, 1 = gshare.
- INIT, 1, counter reset value; must be < 2^CTR_BITS.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- request  in  1  prediction request this cycle.
- req_pc  in  INDEX_BITS  low PC bits of the branch (already word-aligned).
- prediction  out  1  predicted direction, 1 = taken.
- pred_valid  out  1  one-cycle pulse marking a new prediction.
- pred_index  out  INDEX_BITS  table index used; the pipeline carries it to resolution.
- result  in  1  resolved-outcome strobe this cycle.
- res_index  in  INDEX_BITS  index returned with the outcome.
- taken  in  1  actual outcome, valid when result = 1.

Behaviour:
- Reset (clk edge with reset = 1):
  - All counters <= INIT; GHR <= 0; prediction, pred_valid, pred_index <= 0.
  - Reset dominates request and result in the same cycle; neither has any effect.
- Index computation, combinational on the current-cycle GHR:
  - MODE = 0: idx = req_pc.
  - MODE = 1: idx = req_pc XOR zero-extended GHR (GHR occupies the LSBs).
- Prediction, latency 1:
  - On an edge with request = 1: prediction <= table[idx][CTR_BITS-1]; pred_index <= idx; pred_valid <= 1.
  - With request = 0: pred_valid <= 0; prediction and pred_index hold their last values.
- Training, on an edge with result = 1:
  - taken = 1: table[res_index] increments, saturating at 2^CTR_BITS-1.
  - taken = 0: table[res_index] decrements, saturating at 0.
  - GHR <= {GHR[HIST_BITS-2:0], taken}; for HIST_BITS = 1, GHR <= taken.
  - With result = 0: table and GHR unchanged.
- GHR is updated non-speculatively (resolution only); no repair or checkpoint logic.
- Simultaneous request and result, read-before-write:
  - The prediction uses counter values and GHR from before this edge's update, including when idx == res_index.
- No back-pressure: one request and one result may be accepted every cycle.
- Out-of-range res_index cannot occur (full index width).
- Table may be flops or distributed RAM with a synchronous write; the read path must meet the read-before-write rule.

Decomposition:
- Package gshare_pkg:
  - MODE_BIMODAL = 0, MODE_GSHARE = 1 constants.
  - A saturating update function (counter, taken, width) -> next counter, shared with future predictor variants.
- One natural sub-module, branch_history_reg:
  - Parametrised HIST_BITS shift register with synchronous reset and a shift-enable input.
  - Reusable by a tournament predictor.
- Table, index hash and output registers stay in the top module.

Test Plan (INDEX_BITS=4, CTR_BITS=2, HIST_BITS=4, INIT=1 unless stated):
- Reset, then request with req_pc=3, MODE=1 -> next cycle: pred_valid=1, pred_index=3, prediction=0; the following idle cycle gives pred_valid=0 with prediction and pred_index held.
- MODE=0 saturation:
  - 1 taken result at index 5, then request pc=5 -> prediction=1 (counter 2).
  - 3 more taken -> counter 3 (capped); 1 not-taken -> 2, prediction 1.
  - 2 more not-taken -> 0; 1 more not-taken -> stays 0, prediction 0.
- MODE=1 history: results T,T,N,T (any index) -> GHR=4'b1101; request req_pc=4'b0001 -> pred_index=4'b1100, prediction from table[12].
- Same-edge collision, MODE=0: counter[7]=1; request pc=7 together with result index 7 taken -> prediction=0 (old value); a request on the next cycle -> prediction=1.
- Reset mid-operation: train index 2 to 3, then assert reset with request=1 and result=1 -> pred_valid=0, prediction=0, GHR=0; a later request pc=2 -> prediction=0 (counter back to INIT).
- CTR_BITS=3, INIT=3: request -> 0; 1 taken -> 4 -> predicts 1; 10 taken -> caps at 7; 3 not-taken -> 4, still predicts 1.
